cache_mem_responder: RTL and testbench
======================================

# cache_mem_responder

Memory-side responder for the data-cache miss interface. It accepts single-word read and write requests issued by the cache controller, holds each request for a fixed number of cycles to model backing-memory latency, then performs the access and pulses a one-cycle valid strobe. It sits between the cache (`two-way`/direct-mapped variants) and nothing else: it owns the backing word storage for the data side of the pipeline.

## Interface
- `ADDR_WIDTH`, default 16: number of byte-address bits decoded. Storage depth is 2^(ADDR_WIDTH-2) 32-bit words.
- `LATENCY`, default 4: edges from request acceptance to completion. Legal range is 1..15.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `MemRead_wire`, input, 1: read request from the cache.
- `MemWrite_wire`, input, 1: write request from the cache. Wins over read if both are high.
- `MemAddress_wire`, input, 32: byte address. Bits [1:0] are ignored; bits [31:ADDR_WIDTH] are ignored, so addresses alias.
- `MemWriteData_wire`, input, 32: write data.
- `Datamem_wire`, output, 32: read data, registered.
- `MemValid_wire`, output, 1: one-cycle completion strobe, registered.
- `Busy`, output, 1: high while a transaction is outstanding.

## Operation
- **States**
  - IDLE: no transaction outstanding.
  - WAIT: latency countdown in progress.
  - RESP: completion strobe cycle.
- **IDLE**
  - If `MemWrite_wire` or `MemRead_wire` is high at an edge, latch the operation (write has priority), the word address `MemAddress_wire[ADDR_WIDTH-1:2]` and the write data.
  - Load the counter with LATENCY-1 and go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - Request inputs are ignored. Changes to address, data or strobes do not affect the latched transaction.
  - If the counter is nonzero, decrement it.
  - If the counter is 0:
    - Write: store the latched data to storage.
    - Read: load `Datamem_wire` from storage.
    - Set `MemValid_wire` to 1 and go to RESP.
- **RESP**
  - Clear `MemValid_wire` and go to IDLE.
  - Requests are not sampled in this cycle.
- **Datamem_wire**
  - Changes only on read completion; otherwise it holds its last value.
  - Write completions leave it unchanged.
- **Storage**
  - Not cleared by reset.
  - A read after a write to the same word returns the written data.
- **Counter width:** 4 bits. The counter never wraps, because it only decrements while nonzero.
- **Reset, at any time**
  - State goes to IDLE; counter to 0; `MemValid_wire`, `Busy` and `Datamem_wire` go to 0.
  - Any outstanding write is dropped: storage is not modified and no strobe is issued.

## Timing
- Request accepted at edge E0.
- Access is performed and `MemValid_wire` rises at edge E0+LATENCY. It falls at edge E0+LATENCY+1.
- `Busy` is 1 from E0 through E0+LATENCY+1 (WAIT and RESP states).
- For LATENCY=1, `MemValid_wire` is high in the cycle immediately after acceptance.
- The earliest next acceptance is edge E0+LATENCY+2.
  - A request still held high then, such as a cache that has not yet dropped the miss, starts a new transaction.
  - The initiator must deassert within one cycle of the strobe to avoid a duplicate access.
- No combinational path exists from inputs to outputs.

## Test plan
- **Reset state:** assert `rst` with the clock stopped. Required: `MemValid_wire`=0, `Busy`=0, `Datamem_wire`=0.
- **Write then read (LATENCY=4):**
  - Write 0xDEADBEEF to address 0x10 at E0. Required: the strobe is high only between E4 and E5.
  - Then read 0x10. Required: `Datamem_wire`=0xDEADBEEF with the strobe, 4 edges after acceptance.
- **Simultaneous read and write:** read=write=1, address 0x20, data 0x1234. Required: treated as a write; `Datamem_wire` unchanged; a later read of 0x20 returns 0x1234.
- **Mid-transaction input change:**
  - Storage holds [0x10]=0xAAAA and [0x14]=0xBBBB.
  - Accept a read of 0x10, then switch the address to 0x14 during WAIT.
  - Required: response 0xAAAA.
- **Reset mid-write:**
  - [0x30]=0x11 beforehand. Accept a write of 0x55 to 0x30; assert `rst` after E2.
  - Required: no strobe; a subsequent read of 0x30 returns 0x11.
- **Aliasing and back-to-back:**
  - ADDR_WIDTH=16. Write 0x77 to 0x0001_0040, then read 0x0000_0043. Required: 0x77.
  - Hold the read high after its strobe. Required: a second strobe at E0'+LATENCY, where E0' is the edge two cycles after the first strobe.

Source files
------------

// File: rtl/cache_mem_responder.sv
// cache_mem_responder
// Memory-side responder for the data-cache miss interface. Accepts one
// single-word read or write, holds it for LATENCY edges to model
// backing-memory latency, performs the access, then pulses MemValid_wire
// for one cycle. Owns the backing word storage for the data side.
module cache_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_wire,
    input  logic        MemWrite_wire,
    input  logic [31:0] MemAddress_wire,
    input  logic [31:0] MemWriteData_wire,
    output logic [31:0] Datamem_wire,
    output logic        MemValid_wire,
    output logic        Busy
);

    localparam int WORD_BITS = ADDR_WIDTH - 2;
    localparam int DEPTH     = 1 << WORD_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_reg;
    logic [3:0]           cnt_reg;
    logic                 op_write_reg;
    logic [WORD_BITS-1:0] addr_reg;
    logic [31:0]          wdata_reg;
    logic                 mem_we;

    // Backing storage; deliberately has no reset so contents survive rst.
    logic [31:0] mem [0:DEPTH-1];

    // Byte-offset bits and bits above the decoded range are don't-care;
    // high bits simply alias onto the same words.
    logic unused_addr_bits;
    generate
        if (ADDR_WIDTH < 32) begin : g_alias
            assign unused_addr_bits = ^{MemAddress_wire[31:ADDR_WIDTH], MemAddress_wire[1:0]};
        end else begin : g_noalias
            assign unused_addr_bits = ^MemAddress_wire[1:0];
        end
    endgenerate

    // The write happens on the completion edge, from the latched transaction only.
    assign mem_we = (state_reg == WAIT) && (cnt_reg == 4'd0) && op_write_reg;

    // Storage write port, kept free of reset so storage survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    // Transaction FSM: accept, count down latency, complete, strobe for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            op_write_reg  <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            Datamem_wire  <= 32'd0;
            MemValid_wire <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (MemWrite_wire || MemRead_wire) begin
                        // Write has priority when both strobes are high.
                        op_write_reg <= MemWrite_wire;
                        addr_reg     <= MemAddress_wire[ADDR_WIDTH-1:2];
                        wdata_reg    <= MemWriteData_wire;
                        cnt_reg      <= CNT_LOAD;
                        Busy         <= 1'b1;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        // Reads update the data register; writes leave it alone.
                        if (!op_write_reg) begin
                            Datamem_wire <= mem[addr_reg];
                        end
                        MemValid_wire <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    // Requests are not sampled here, giving one dead cycle.
                    MemValid_wire <= 1'b0;
                    Busy          <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: begin
                    MemValid_wire <= 1'b0;
                    Busy          <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed testbench for cache_mem_responder (ADDR_WIDTH=16, LATENCY=4).
module tb_cache_mem_responder;

    localparam int LAT = 4;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic        MemRead_wire;
    logic        MemWrite_wire;
    logic [31:0] MemAddress_wire;
    logic [31:0] MemWriteData_wire;
    logic [31:0] Datamem_wire;
    logic        MemValid_wire;
    logic        Busy;

    int checks;
    int errors;
    logic [31:0] cur_data;   // expected content of Datamem_wire

    cache_mem_responder #(
        .ADDR_WIDTH(16),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .MemRead_wire(MemRead_wire),
        .MemWrite_wire(MemWrite_wire),
        .MemAddress_wire(MemAddress_wire),
        .MemWriteData_wire(MemWriteData_wire),
        .Datamem_wire(Datamem_wire),
        .MemValid_wire(MemValid_wire),
        .Busy(Busy)
    );

    // Clock can be held stopped for the initial reset check.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction. pre=1: the request is already being driven (held from
    // the previous one). hold=1: strobes stay high after acceptance; otherwise
    // they drop and address/data are scrambled to prove they were latched.
    task automatic txn(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] rexp,
                       input logic hold, input logic pre, input string tag);
        logic [31:0] exp_d;
        if (!pre) begin
            @(negedge clk);
            MemWrite_wire     = wr;
            MemRead_wire      = rd;
            MemAddress_wire   = addr;
            MemWriteData_wire = data;
        end
        exp_d = wr ? cur_data : rexp;
        @(posedge clk);                      // E0: acceptance
        #1;
        check({tag, "_busy_e0"}, 32'(Busy), 32'd1);
        check({tag, "_valid_e0"}, 32'(MemValid_wire), 32'd0);
        if (!hold) begin
            MemWrite_wire     = 1'b0;
            MemRead_wire      = 1'b0;
            MemAddress_wire   = addr ^ 32'h4;
            MemWriteData_wire = ~data;
        end
        for (int i = 1; i < LAT; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_valid_wait"}, 32'(MemValid_wire), 32'd0);
        end
        @(posedge clk);                      // E0+LAT: completion
        #1;
        check({tag, "_valid_done"}, 32'(MemValid_wire), 32'd1);
        check({tag, "_data"}, Datamem_wire, exp_d);
        cur_data = exp_d;
        @(posedge clk);                      // E0+LAT+1: strobe falls
        #1;
        check({tag, "_valid_fall"}, 32'(MemValid_wire), 32'd0);
        check({tag, "_busy_fall"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        cur_data          = 32'd0;
        clk_en            = 1'b0;
        MemRead_wire      = 1'b0;
        MemWrite_wire     = 1'b0;
        MemAddress_wire   = 32'd0;
        MemWriteData_wire = 32'd0;

        // Reset with the clock stopped: async reset must act alone.
        rst = 1'b1;
        #2;
        check("rst_valid", 32'(MemValid_wire), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_data", Datamem_wire, 32'd0);
        #10;
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Write then read.
        txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "wr10");
        txn(1'b0, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd10");

        // Both strobes high: treated as a write.
        txn(1'b1, 1'b1, 32'h20, 32'h1234, 32'h0, 1'b0, 1'b0, "rdwr20");
        txn(1'b0, 1'b1, 32'h20, 32'h0, 32'h1234, 1'b0, 1'b0, "rd20");

        // Address switched to 0x14 during WAIT must not matter.
        txn(1'b1, 1'b0, 32'h10, 32'hAAAA, 32'h0, 1'b0, 1'b0, "wr10b");
        txn(1'b1, 1'b0, 32'h14, 32'hBBBB, 32'h0, 1'b0, 1'b0, "wr14");
        txn(1'b0, 1'b1, 32'h10, 32'h0, 32'hAAAA, 1'b0, 1'b0, "rd10_mid");

        // Reset mid-write: no strobe, storage untouched.
        txn(1'b1, 1'b0, 32'h30, 32'h11, 32'h0, 1'b0, 1'b0, "wr30");
        @(negedge clk);
        MemWrite_wire     = 1'b1;
        MemAddress_wire   = 32'h30;
        MemWriteData_wire = 32'h55;
        @(posedge clk);                      // E0
        #1;
        MemWrite_wire = 1'b0;
        @(posedge clk);                      // E1
        @(posedge clk);                      // E2
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(MemValid_wire), 32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_data", Datamem_wire, 32'd0);
        cur_data = 32'd0;
        #2;
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk);
            #1;
            check("midrst_nostrobe", 32'(MemValid_wire), 32'd0);
        end
        txn(1'b0, 1'b1, 32'h30, 32'h0, 32'h11, 1'b0, 1'b0, "rd30");

        // Aliasing above ADDR_WIDTH and in the byte offset; then back-to-back.
        txn(1'b1, 1'b0, 32'h0001_0040, 32'h77, 32'h0, 1'b0, 1'b0, "wr_alias");
        txn(1'b0, 1'b1, 32'h0000_0043, 32'h0, 32'h77, 1'b1, 1'b0, "rd_alias");
        txn(1'b0, 1'b1, 32'h0000_0043, 32'h0, 32'h77, 1'b0, 1'b1, "rd_b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
